// File: rtl/adpcm_encoder.sv
// IMA ADPCM encoder: 16-bit signed PCM in, 4-bit code out, with a 7-state successive-approximation FSM.
// Optional ADPCM_ENC_BYTE_PACK_EN packs two codes per output byte, with the first code in the low nibble.
module adpcm_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_valid,
  input  logic [15:0] init_pred,
  input  logic [6:0]  init_index,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_sample,
  output logic        code_valid,
  input  logic        code_ready,
  output logic [7:0]  code_out,
  output logic [15:0] pred_out,
  output logic [6:0]  index_out
);

  typedef enum logic [2:0] {IDLE, DIFF, Q2, Q1, Q0, UPD, OUT} state_t;

  state_t      state_r;
  logic [15:0] sample_r, pred_r, step_r;
  logic [6:0]  index_r;
  logic [16:0] mag_r;
  logic [17:0] vpdiff_r;
  logic        sign_r;
  logic [2:0]  code_r;
`ifdef ADPCM_ENC_BYTE_PACK_EN
  logic [3:0]  half_r;
  logic        half_valid_r;
`endif

  function automatic logic [15:0] step_lookup(input logic [6:0] idx);
    case (idx)
      7'd0: return 16'd7;      7'd1: return 16'd8;      7'd2: return 16'd9;      7'd3: return 16'd10;
      7'd4: return 16'd11;     7'd5: return 16'd12;     7'd6: return 16'd13;     7'd7: return 16'd14;
      7'd8: return 16'd16;     7'd9: return 16'd17;     7'd10: return 16'd19;    7'd11: return 16'd21;
      7'd12: return 16'd23;    7'd13: return 16'd25;    7'd14: return 16'd28;    7'd15: return 16'd31;
      7'd16: return 16'd34;    7'd17: return 16'd37;    7'd18: return 16'd41;    7'd19: return 16'd45;
      7'd20: return 16'd50;    7'd21: return 16'd55;    7'd22: return 16'd60;    7'd23: return 16'd66;
      7'd24: return 16'd73;    7'd25: return 16'd80;    7'd26: return 16'd88;    7'd27: return 16'd97;
      7'd28: return 16'd107;   7'd29: return 16'd118;   7'd30: return 16'd130;   7'd31: return 16'd143;
      7'd32: return 16'd157;   7'd33: return 16'd173;   7'd34: return 16'd190;   7'd35: return 16'd209;
      7'd36: return 16'd230;   7'd37: return 16'd253;   7'd38: return 16'd279;   7'd39: return 16'd307;
      7'd40: return 16'd337;   7'd41: return 16'd371;   7'd42: return 16'd408;   7'd43: return 16'd449;
      7'd44: return 16'd494;   7'd45: return 16'd544;   7'd46: return 16'd598;   7'd47: return 16'd658;
      7'd48: return 16'd724;   7'd49: return 16'd796;   7'd50: return 16'd876;   7'd51: return 16'd963;
      7'd52: return 16'd1060;  7'd53: return 16'd1166;  7'd54: return 16'd1282;  7'd55: return 16'd1411;
      7'd56: return 16'd1552;  7'd57: return 16'd1707;  7'd58: return 16'd1878;  7'd59: return 16'd2066;
      7'd60: return 16'd2272;  7'd61: return 16'd2499;  7'd62: return 16'd2749;  7'd63: return 16'd3024;
      7'd64: return 16'd3327;  7'd65: return 16'd3660;  7'd66: return 16'd4026;  7'd67: return 16'd4428;
      7'd68: return 16'd4871;  7'd69: return 16'd5358;  7'd70: return 16'd5894;  7'd71: return 16'd6484;
      7'd72: return 16'd7132;  7'd73: return 16'd7845;  7'd74: return 16'd8630;  7'd75: return 16'd9493;
      7'd76: return 16'd10442; 7'd77: return 16'd11487; 7'd78: return 16'd12635; 7'd79: return 16'd13899;
      7'd80: return 16'd15289; 7'd81: return 16'd16818; 7'd82: return 16'd18500; 7'd83: return 16'd20350;
      7'd84: return 16'd22385; 7'd85: return 16'd24623; 7'd86: return 16'd27086; 7'd87: return 16'd29794;
      default: return 16'd32767;
    endcase
  endfunction

  // The 16-entry index table repeats for both signs, so only the magnitude bits select it.
  function automatic logic signed [7:0] idx_delta(input logic [2:0] mag_code);
    case (mag_code)
      3'd4:    return 8'sd2;
      3'd5:    return 8'sd4;
      3'd6:    return 8'sd6;
      3'd7:    return 8'sd8;
      default: return -8'sd1;
    endcase
  endfunction

  logic signed [16:0] diff_s;
  logic [16:0]        comparand_s;
  logic               take_s;
  logic [3:0]         code_s;
  logic signed [18:0] pred_sum_s;
  logic [15:0]        pred_next_s;
  logic signed [7:0]  idx_sum_s;
  logic [6:0]         index_next_s;

  always_comb begin
    diff_s = $signed({sample_r[15], sample_r}) - $signed({pred_r[15], pred_r});
    case (state_r)
      Q2:      comparand_s = {1'b0, step_r};
      Q1:      comparand_s = {2'b00, step_r[15:1]};
      default: comparand_s = {3'b000, step_r[15:2]};
    endcase
    take_s = (mag_r >= comparand_s);
    code_s = {sign_r, code_r};
    if (sign_r) pred_sum_s = $signed({{3{pred_r[15]}}, pred_r}) - $signed({1'b0, vpdiff_r});
    else        pred_sum_s = $signed({{3{pred_r[15]}}, pred_r}) + $signed({1'b0, vpdiff_r});
    if (pred_sum_s > 19'sd32767)       pred_next_s = 16'h7fff;
    else if (pred_sum_s < -19'sd32768) pred_next_s = 16'h8000;
    else                               pred_next_s = pred_sum_s[15:0];
    idx_sum_s = $signed({1'b0, index_r}) + idx_delta(code_r);
    if (idx_sum_s < 8'sd0)       index_next_s = 7'd0;
    else if (idx_sum_s > 8'sd88) index_next_s = 7'd88;
    else                         index_next_s = idx_sum_s[6:0];
  end

  assign in_ready  = (state_r == IDLE) && !init_valid;
  assign pred_out  = pred_r;
  assign index_out = index_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      sample_r   <= 16'd0;
      pred_r     <= 16'd0;
      step_r     <= 16'd0;
      index_r    <= 7'd0;
      mag_r      <= 17'd0;
      vpdiff_r   <= 18'd0;
      sign_r     <= 1'b0;
      code_r     <= 3'd0;
      code_valid <= 1'b0;
      code_out   <= 8'd0;
`ifdef ADPCM_ENC_BYTE_PACK_EN
      half_r       <= 4'd0;
      half_valid_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (init_valid) begin
            pred_r  <= init_pred;
            index_r <= (init_index > 7'd88) ? 7'd88 : init_index;
`ifdef ADPCM_ENC_BYTE_PACK_EN
            half_valid_r <= 1'b0;
`endif
          end else if (in_valid) begin
            sample_r <= in_sample;
            state_r  <= DIFF;
          end
        end
        DIFF: begin
          sign_r   <= diff_s[16];
          mag_r    <= diff_s[16] ? 17'(-diff_s) : 17'(diff_s);
          step_r   <= step_lookup(index_r);
          vpdiff_r <= {5'd0, step_lookup(index_r) >> 3};
          code_r   <= 3'd0;
          state_r  <= Q2;
        end
        Q2, Q1, Q0: begin
          if (take_s) begin
            mag_r    <= mag_r - comparand_s;
            vpdiff_r <= vpdiff_r + {1'b0, comparand_s};
            case (state_r)
              Q2:      code_r[2] <= 1'b1;
              Q1:      code_r[1] <= 1'b1;
              default: code_r[0] <= 1'b1;
            endcase
          end
          case (state_r)
            Q2:      state_r <= Q1;
            Q1:      state_r <= Q0;
            default: state_r <= UPD;
          endcase
        end
        UPD: begin
          pred_r  <= pred_next_s;
          index_r <= index_next_s;
`ifdef ADPCM_ENC_BYTE_PACK_EN
          if (half_valid_r) begin
            code_out     <= {code_s, half_r};
            code_valid   <= 1'b1;
            half_valid_r <= 1'b0;
            state_r      <= OUT;
          end else begin
            half_r       <= code_s;
            half_valid_r <= 1'b1;
            state_r      <= IDLE;
          end
`else
          code_out   <= {4'd0, code_s};
          code_valid <= 1'b1;
          state_r    <= OUT;
`endif
        end
        OUT: begin
          if (code_ready) begin
            code_valid <= 1'b0;
            state_r    <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
